prio_encoder_seq: RTL and testbench

//   Parametrised, registered successor to the 8-to-3 switch encoder. Switches and

---
 rtl/prio_encoder_seq.sv | 126 ++++++++++++
 tb/tb_prio_encoder_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder_seq
// Brief    : Synchronised, debounced, direction-selectable priority encoder
//            with hold, change strobe/counter and registered 7-seg digit.
// Revision : 1.0  initial release
// ============================================================================
module prio_encoder_seq #(
    parameter int N          = 8,
    parameter int W          = $clog2(N),
    parameter int DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x,
    input  logic         en,
    input  logic         lsb_first,
    input  logic         hold,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         changed,
    output logic [7:0]   chg_cnt,
    output logic [7:0]   seg
);

    localparam int            c_CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEB_CYCLES - 1);

    logic [N:0]         r_sync1;
    logic [N:0]         r_s;
    logic [N:0]         r_cand;
    logic [N:0]         r_stable;
    logic [c_CNT_W-1:0] r_cnt;

    logic [W-1:0]       w_idx;
    logic               w_v;
    logic [6:0]         w_glyph;

    // Bit N carries en alongside x so both are debounced as one vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_s      <= '0;
            r_cand   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= {en, x};
            r_s     <= r_sync1;
            if (r_s != r_cand) begin
                r_cand <= r_s;
                r_cnt  <= '0;
            end else if (r_cnt == c_CNT_MAX && r_cand != r_stable) begin
                r_stable <= r_cand;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // Later loop iterations overwrite earlier ones, so scan order picks the winner.
    always_comb begin
        w_idx = '0;
        w_v   = 1'b0;
        if (r_stable[N] && (|r_stable[N-1:0])) begin
            w_v = 1'b1;
            if (lsb_first) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (r_stable[i]) w_idx = W'(i);
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (r_stable[i]) w_idx = W'(i);
                end
            end
        end
    end

    always_comb begin
        w_glyph = 7'h7F;
        case (4'(w_idx))
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h10;
            4'hA: w_glyph = 7'h08;
            4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;
            4'hD: w_glyph = 7'h21;
            4'hE: w_glyph = 7'h06;
            4'hF: w_glyph = 7'h0E;
            default: w_glyph = 7'h7F;
        endcase
    end

    // seg is registered with y/valid so hold freezes the whole display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            valid   <= 1'b0;
            changed <= 1'b0;
            chg_cnt <= 8'd0;
            seg     <= 8'hFF;
        end else if (hold) begin
            changed <= 1'b0;
        end else begin
            y     <= w_idx;
            valid <= w_v;
            seg   <= w_v ? {~lsb_first, w_glyph} : 8'hFF;
            if ({w_idx, w_v} != {y, valid}) begin
                changed <= 1'b1;
                chg_cnt <= chg_cnt + 8'd1;
            end else begin
                changed <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_encoder_seq
// Brief    : Directed + randomized checks of prio_encoder_seq against a
//            history-based behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_prio_encoder_seq;

    localparam int N   = 8;
    localparam int W   = 3;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] x = '0;
    logic         en = 1'b0;
    logic         lsb_first = 1'b0;
    logic         hold = 1'b0;
    logic [W-1:0] y;
    logic         valid;
    logic         changed;
    logic [7:0]   chg_cnt;
    logic [7:0]   seg;

    prio_encoder_seq #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .x(x), .en(en), .lsb_first(lsb_first), .hold(hold),
        .y(y), .valid(valid), .changed(changed), .chg_cnt(chg_cnt), .seg(seg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Active-low gfedcba glyphs for hex digits.
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: s is the raw vector two edges late; a value is committed once the
    // last DEB+1 values of s seen at edges are all identical.
    logic [N:0]   m_raw_prev, m_s, m_stable, m_nxt;
    logic [N:0]   m_hist[$];
    logic [W-1:0] m_y;
    logic         m_valid, m_changed;
    logic [7:0]   m_cnt, m_seg;

    function automatic void model_reset();
        m_raw_prev = '0;
        m_s        = '0;
        m_stable   = '0;
        m_hist     = {};
        m_hist.push_back('0);
        m_y        = '0;
        m_valid    = 1'b0;
        m_changed  = 1'b0;
        m_cnt      = 8'd0;
        m_seg      = 8'hFF;
    endfunction

    function automatic void encode(input logic [N:0] st, input logic lsb,
                                   output logic [W-1:0] idx, output logic v);
        int val;
        val = int'(st[N-1:0]);
        if (!st[N] || val == 0) begin
            idx = '0;
            v   = 1'b0;
        end else begin
            v   = 1'b1;
            idx = lsb ? W'($clog2(val & -val)) : W'($clog2(val + 1) - 1);
        end
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [W-1:0] e_idx;
        logic         e_v;
        bit           all_eq;
        if (rst) begin
            model_reset();
        end else begin
            m_hist.push_back(m_s);
            if (m_hist.size() > DEB + 1) void'(m_hist.pop_front());
            m_nxt = m_stable;
            if (m_hist.size() == DEB + 1) begin
                all_eq = 1'b1;
                foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) all_eq = 1'b0;
                if (all_eq) m_nxt = m_hist[0];
            end
            if (!hold) begin
                encode(m_stable, lsb_first, e_idx, e_v);
                m_changed = (e_idx != m_y) || (e_v != m_valid);
                if (m_changed) m_cnt = m_cnt + 8'd1;
                m_y     = e_idx;
                m_valid = e_v;
                m_seg   = e_v ? {~lsb_first, glyph_tab[4'(e_idx)]} : 8'hFF;
            end else begin
                m_changed = 1'b0;
            end
            m_stable   = m_nxt;
            m_s        = m_raw_prev;
            m_raw_prev = {en, x};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_y", 32'(y), 32'(m_y));
            check("m_valid", 32'(valid), 32'(m_valid));
            check("m_changed", 32'(changed), 32'(m_changed));
            check("m_chg_cnt", 32'(chg_cnt), 32'(m_cnt));
            check("m_seg", 32'(seg), 32'(m_seg));
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pulses;
        int bad_y;
        int dur;

        model_reset();
        rst = 1'b1;
        wait_neg(3);
        rst = 1'b0;
        chk_en = 1'b1;

        // Mid-run async reset with all requests active
        en = 1'b1;
        x  = 8'hFF;
        wait_neg(12);
        check("ff_y", 32'(y), 32'd7);
        check("ff_valid", 32'(valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_y", 32'(y), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_cnt", 32'(chg_cnt), 32'd0);
        check("rst_seg", 32'(seg), 32'hFF);
        x = 8'h00;
        wait_neg(2);
        rst = 1'b0;
        wait_neg(12);

        // Latency of a clean change
        x = 8'b0010_0100;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            if (e == 7) check("lat_pre_valid", 32'(valid), 32'd0);
            if (e == 8) begin
                check("lat_y", 32'(y), 32'd5);
                check("lat_valid", 32'(valid), 32'd1);
                check("lat_changed", 32'(changed), 32'd1);
                check("lat_cnt", 32'(chg_cnt), 32'd1);
                check("lat_seg", 32'(seg), 32'h92);
            end
            if (e == 9) check("lat_pulse_end", 32'(changed), 32'd0);
        end

        // Direction toggle re-encodes on the next edge
        lsb_first = 1'b1;
        @(negedge clk);
        check("lsb_y", 32'(y), 32'd2);
        check("lsb_changed", 32'(changed), 32'd1);
        check("lsb_seg", 32'(seg), 32'h24);
        check("lsb_cnt", 32'(chg_cnt), 32'd2);

        // Short glitch must not propagate
        lsb_first = 1'b0;
        x = 8'h80;
        wait_neg(12);
        check("gl_y0", 32'(y), 32'd7);
        x = 8'h00;
        wait_neg(3);
        x = 8'h80;
        pulses = 0;
        bad_y  = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (changed) pulses++;
            if (y != 3'd7) bad_y++;
        end
        check("gl_pulses", 32'(pulses), 32'd0);
        check("gl_bad_y", 32'(bad_y), 32'd0);

        // Hold freezes outputs; release loads current result
        hold = 1'b1;
        x = 8'h01;
        pulses = 0;
        bad_y  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (changed) pulses++;
            if (y != 3'd7) bad_y++;
        end
        check("hold_pulses", 32'(pulses), 32'd0);
        check("hold_bad_y", 32'(bad_y), 32'd0);
        hold = 1'b0;
        @(negedge clk);
        check("rel_y", 32'(y), 32'd0);
        check("rel_valid", 32'(valid), 32'd1);
        check("rel_changed", 32'(changed), 32'd1);

        // Enable low blanks the output
        en = 1'b0;
        wait_neg(12);
        check("en0_valid", 32'(valid), 32'd0);
        check("en0_y", 32'(y), 32'd0);
        check("en0_seg", 32'(seg), 32'hFF);

        // Counter wrap after 256 changes from reset
        x = 8'h00;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            x = (i % 2 == 0) ? 8'h01 : 8'h02;
            wait_neg(10);
            if (i == 254) check("wrap_255", 32'(chg_cnt), 32'd255);
        end
        wait_neg(4);
        check("wrap_0", 32'(chg_cnt), 32'd0);

        // Randomized phase
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(0, 2) != 0) x = N'($urandom);
            en        = ($urandom_range(0, 7) != 0);
            lsb_first = $urandom_range(0, 1) != 0;
            hold      = ($urandom_range(0, 4) == 0);
            dur = (it % 3 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(6, 12));
            wait_neg(dur);
        end
        hold = 1'b0;
        wait_neg(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
